spi_slave_rx: RTL

- SPI receive endpoint for our 12-bit serial link; the peripheral-side counterpart of the SPI master transmitter.
- Oversamples the asynchronous sclk/cs/mosi lines in the system clk domain and samples mosi on sclk falling edges, mid-bit, since the transmitter launches data on sclk rising edges.
- Assembles the frame LSB-first and presents it as a parallel word with a one-cycle done strobe or an err strobe.

---
 rtl/spi_slave_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive endpoint for the 12-bit serial link.
//
// The asynchronous sclk/cs/mosi lines are oversampled in the i_clk domain.
// mosi is sampled on sclk falling edges, in the middle of the bit, because
// the transmitter launches data on rising edges. After cs falls, the first
// LEAD_EDGES falling edges are discarded. The next WIDTH bits are assembled
// LSB-first. A cs rising edge ends the frame with either a done or an err
// strobe.
//
// Ports:
//   i_clk    system clock, all logic on its rising edge
//   i_rstn   synchronous active-low reset
//   i_sclk   serial clock from master (asynchronous)
//   i_cs     chip select from master, active low (asynchronous)
//   i_mosi   serial data from master (asynchronous)
//   o_dout   last good received word
//   o_done   one-cycle pulse: o_dout updated with a good frame
//   o_err    one-cycle pulse: frame ended with bit count != WIDTH
//   o_busy   high while a frame is in progress
module spi_slave_rx #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned LEAD_EDGES  = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_sclk,
    input  logic             i_cs,
    input  logic             i_mosi,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy
);

    localparam int unsigned CntW  = $clog2(WIDTH + 1);
    localparam int unsigned IdxW  = $clog2(WIDTH);
    localparam int unsigned LeadW = (LEAD_EDGES > 1) ? $clog2(LEAD_EDGES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StLead, StShift, StTail} state_t;

    // Input synchronizers plus edge-detect history
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;

    // cs flops reset to 0 so a cs line already high at reset release is seen
    // as a rise (ignored in idle) rather than a false fall.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_fall = r_sclk_hist & ~w_sclk;
    assign w_cs_fall   = r_cs_hist & ~w_cs;
    assign w_cs_rise   = ~r_cs_hist & w_cs;

    // Frame state
    state_t            r_state;
    logic [LeadW-1:0]  r_lead_cnt;
    logic [CntW-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_dout;
    logic              r_done;
    logic              r_err;

    state_t            w_state_next;
    logic [LeadW-1:0]  w_lead_next;
    logic [CntW-1:0]   w_bit_next;
    logic [WIDTH-1:0]  w_shift_next;
    logic [WIDTH-1:0]  w_dout_next;
    logic              w_done_next;
    logic              w_err_next;
    logic [IdxW-1:0]   w_bit_idx;

    assign w_bit_idx = r_bit_cnt[IdxW-1:0];

    always_comb begin
        w_state_next = r_state;
        w_lead_next  = r_lead_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_dout_next  = r_dout;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;

        if (r_state == StIdle) begin
            if (w_cs_fall) begin
                w_lead_next  = '0;
                w_bit_next   = '0;
                w_shift_next = '0;
                w_state_next = (LEAD_EDGES == 0) ? StShift : StLead;
            end
        end else if (w_cs_rise) begin
            // cs rise beats a coincident sclk fall: that bit is dropped
            w_state_next = StIdle;
            if (r_bit_cnt == CntW'(WIDTH)) begin
                w_dout_next = r_shift;
                w_done_next = 1'b1;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (w_sclk_fall) begin
            case (r_state)
                StLead: begin
                    w_lead_next = r_lead_cnt + LeadW'(1);
                    if (w_lead_next == LeadW'(LEAD_EDGES)) begin
                        w_state_next = StShift;
                    end
                end
                StShift: begin
                    w_shift_next[w_bit_idx] = w_mosi;
                    w_bit_next              = r_bit_cnt + CntW'(1);
                    if (w_bit_next == CntW'(WIDTH)) begin
                        w_state_next = StTail;
                    end
                end
                default: ;  // tail: filler and extra clocks are ignored
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= StIdle;
            r_lead_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_lead_cnt <= w_lead_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_dout     <= w_dout_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
        end
    end

    assign o_dout = r_dout;
    assign o_done = r_done;
    assign o_err  = r_err;
    assign o_busy = (r_state != StIdle);

endmodule
